// File: rtl/time_entry_ctrl_if.sv
// time_entry_ctrl_if: Aclock load bus carrying the edited time plus its load strobes
interface time_entry_ctrl_if;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    modport master (output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm);
    modport slave  (input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm);
endinterface

// File: rtl/time_entry_ctrl.sv
// time_entry_ctrl: push-button time/alarm editor driving the Aclock load bus
module time_entry_ctrl #(
    parameter int LD_HOLD        = 2,
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    btn_mode,
    input  logic                    btn_next,
    input  logic                    btn_inc,
    input  logic                    btn_ok,
    input  logic [1:0]              cur_H1,
    input  logic [3:0]              cur_H0,
    input  logic [3:0]              cur_M1,
    input  logic [3:0]              cur_M0,
    time_entry_ctrl_if.master       ld,
    output logic                    editing,
    output logic                    edit_alarm,
    output logic [1:0]              field_sel
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = (LD_HOLD > 1) ? $clog2(LD_HOLD) : 1;
    typedef enum logic [1:0] {IDLE, EDIT_TIME, EDIT_ALARM, LOAD} state_t;
    state_t        state_q, state_d;
    logic [1:0]    h1_q, h1_d, ah1_q, ah1_d;
    logic [3:0]    h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
    logic [3:0]    ah0_q, ah0_d, am1_q, am1_d, am0_q, am0_d;
    logic [1:0]    field_q, field_d;
    logic [TW-1:0] to_q, to_d;
    logic [LW-1:0] ld_q, ld_d;
    logic          tgt_alarm_q, tgt_alarm_d;
    logic          ld_time_q, ld_time_d, ld_alarm_q, ld_alarm_d;
    logic [3:0]    prev_q, btn, edges;
    logic          e_mode, e_next, e_inc, e_ok;
    logic [1:0]    h1_inc;
    logic [3:0]    h0_inc, m1_inc, m0_inc;
    assign btn    = {btn_mode, btn_next, btn_inc, btn_ok};
    assign edges  = btn & ~prev_q;
    assign e_mode = edges[3];
    assign e_next = edges[2];
    assign e_inc  = edges[1];
    assign e_ok   = edges[0];
    // H0 wrap depends on H1 so the buffer never leaves 00:00-23:59
    assign h1_inc = (h1_q == 2'd2) ? 2'd0 : h1_q + 2'd1;
    assign h0_inc = ((h1_q == 2'd2 && h0_q == 4'd3) || h0_q == 4'd9) ? 4'd0 : h0_q + 4'd1;
    assign m1_inc = (m1_q == 4'd5) ? 4'd0 : m1_q + 4'd1;
    assign m0_inc = (m0_q == 4'd9) ? 4'd0 : m0_q + 4'd1;
    always_comb begin
        state_d     = state_q;
        h1_d        = h1_q;
        h0_d        = h0_q;
        m1_d        = m1_q;
        m0_d        = m0_q;
        ah1_d       = ah1_q;
        ah0_d       = ah0_q;
        am1_d       = am1_q;
        am0_d       = am0_q;
        field_d     = field_q;
        to_d        = to_q;
        ld_d        = ld_q;
        tgt_alarm_d = tgt_alarm_q;
        ld_time_d   = ld_time_q;
        ld_alarm_d  = ld_alarm_q;
        case (state_q)
            IDLE: begin
                if (e_mode) begin
                    state_d = EDIT_TIME;
                    {h1_d, h0_d, m1_d, m0_d} = {cur_H1, cur_H0, cur_M1, cur_M0};
                    field_d = 2'd0;
                    to_d    = '0;
                end
            end
            EDIT_TIME, EDIT_ALARM: begin
                to_d = (|edges) ? '0 : to_q + 1'b1;
                if (e_ok) begin
                    state_d     = LOAD;
                    tgt_alarm_d = (state_q == EDIT_ALARM);
                    ld_d        = LW'(LD_HOLD - 1);
                    ld_time_d   = (state_q == EDIT_TIME);
                    ld_alarm_d  = (state_q == EDIT_ALARM);
                    if (state_q == EDIT_ALARM)
                        {ah1_d, ah0_d, am1_d, am0_d} = {h1_q, h0_q, m1_q, m0_q};
                end else if (e_mode) begin
                    state_d = (state_q == EDIT_TIME) ? EDIT_ALARM : IDLE;
                    if (state_q == EDIT_TIME) begin
                        {h1_d, h0_d, m1_d, m0_d} = {ah1_q, ah0_q, am1_q, am0_q};
                        field_d = 2'd0;
                    end
                end else if (e_next) begin
                    field_d = field_q + 2'd1;
                end else if (e_inc) begin
                    h1_d = (field_q == 2'd0) ? h1_inc : h1_q;
                    h0_d = (field_q == 2'd0) ? ((h1_inc == 2'd2 && h0_q > 4'd3) ? 4'd3 : h0_q) :
                           (field_q == 2'd1) ? h0_inc : h0_q;
                    m1_d = (field_q == 2'd2) ? m1_inc : m1_q;
                    m0_d = (field_q == 2'd3) ? m0_inc : m0_q;
                end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    to_d    = '0;
                end
            end
            LOAD: begin
                if (ld_q == '0) begin
                    state_d    = IDLE;
                    ld_time_d  = 1'b0;
                    ld_alarm_d = 1'b0;
                end else begin
                    ld_d = ld_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            {h1_q, h0_q, m1_q, m0_q}     <= '0;
            {ah1_q, ah0_q, am1_q, am0_q} <= '0;
            field_q     <= 2'd0;
            to_q        <= '0;
            ld_q        <= '0;
            tgt_alarm_q <= 1'b0;
            ld_time_q   <= 1'b0;
            ld_alarm_q  <= 1'b0;
            prev_q      <= 4'hF;
        end else begin
            state_q     <= state_d;
            {h1_q, h0_q, m1_q, m0_q}     <= {h1_d, h0_d, m1_d, m0_d};
            {ah1_q, ah0_q, am1_q, am0_q} <= {ah1_d, ah0_d, am1_d, am0_d};
            field_q     <= field_d;
            to_q        <= to_d;
            ld_q        <= ld_d;
            tgt_alarm_q <= tgt_alarm_d;
            ld_time_q   <= ld_time_d;
            ld_alarm_q  <= ld_alarm_d;
            prev_q      <= btn;
        end
    end
    assign ld.H_in1    = h1_q;
    assign ld.H_in0    = h0_q;
    assign ld.M_in1    = m1_q;
    assign ld.M_in0    = m0_q;
    assign ld.LD_time  = ld_time_q;
    assign ld.LD_alarm = ld_alarm_q;
    assign editing     = (state_q == EDIT_TIME) || (state_q == EDIT_ALARM);
    assign edit_alarm  = (state_q == EDIT_ALARM) || (state_q == LOAD && tgt_alarm_q);
    assign field_sel   = field_q;
endmodule

// File: tb/tb_time_entry_ctrl.sv
// tb_time_entry_ctrl: vector table, directed corner sequences and randomized run against a time-of-day model
module tb_time_entry_ctrl;
    localparam int LDH = 2;
    localparam int TO  = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic b_mode = 1'b0, b_next = 1'b0, b_inc = 1'b0, b_ok = 1'b0;
    logic [1:0] cur_H1 = 2'd0;
    logic [3:0] cur_H0 = 4'd0, cur_M1 = 4'd0, cur_M0 = 4'd0;
    logic editing, edit_alarm;
    logic [1:0] field_sel;
    time_entry_ctrl_if bus ();
    time_entry_ctrl #(.LD_HOLD(LDH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(b_mode), .btn_next(b_next), .btn_inc(b_inc), .btn_ok(b_ok),
        .cur_H1(cur_H1), .cur_H0(cur_H0), .cur_M1(cur_M1), .cur_M0(cur_M0),
        .ld(bus.master), .editing(editing), .edit_alarm(edit_alarm), .field_sel(field_sel)
    );
    always #5 clk = ~clk;
    int errors = 0, checks = 0;
    // model: 0 idle, 1 editing time, 2 editing alarm, 3 loading; times kept as hour/minute numbers
    int ms, mh, mm, ah, am, fld, idle, left;
    bit to_al;
    logic [3:0] p;
    typedef struct {
        logic [3:0]  b;
        logic [13:0] digits;
        logic [5:0]  ctl;
    } vec_t;
    vec_t tbl[11];
    function automatic logic [13:0] hm(input int h, input int m);
        return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction
    function automatic logic [13:0] dut_digits();
        return {bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0};
    endfunction
    function automatic logic [5:0] dut_ctl();
        return {bus.LD_time, bus.LD_alarm, editing, edit_alarm, field_sel};
    endfunction
    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask
    task automatic model_reset();
        ms = 0; mh = 0; mm = 0; ah = 0; am = 0; fld = 0; idle = 0; left = 0; to_al = 0; p = 4'hF;
    endtask
    task automatic bump();
        int t, lim;
        case (fld)
            0: begin t = (mh / 10 + 1) % 3; mh = t * 10 + mh % 10; if (mh > 23) mh = 23; end
            1: begin lim = (mh / 10 == 2) ? 4 : 10; mh = (mh / 10) * 10 + (mh % 10 + 1) % lim; end
            2: mm = ((mm / 10 + 1) % 6) * 10 + mm % 10;
            default: mm = (mm / 10) * 10 + (mm % 10 + 1) % 10;
        endcase
    endtask
    task automatic model_clk(input logic [3:0] b);
        logic [3:0] e;
        e = b & ~p;
        p = b;
        if (ms == 0) begin
            if (e[3]) begin
                ms = 1; mh = cur_H1 * 10 + cur_H0; mm = cur_M1 * 10 + cur_M0; fld = 0; idle = 0;
            end
        end else if (ms == 3) begin
            left--;
            if (left == 0) ms = 0;
        end else begin
            if (e != 0) idle = 0; else idle++;
            if (e[0]) begin
                to_al = (ms == 2);
                if (to_al) begin ah = mh; am = mm; end
                ms = 3; left = LDH;
            end else if (e[3]) begin
                if (ms == 1) begin ms = 2; mh = ah; mm = am; fld = 0; idle = 0; end
                else ms = 0;
            end else if (e[2]) fld = (fld + 1) % 4;
            else if (e[1]) bump();
            else if (idle == TO) begin ms = 0; idle = 0; end
        end
    endtask
    task automatic check_all(input string tag);
        logic [5:0] c;
        c = {ms == 3 && !to_al, ms == 3 && to_al, ms == 1 || ms == 2, ms == 2 || (ms == 3 && to_al), 2'(fld)};
        chk({tag, ".time"}, 16'(dut_digits()), 16'(hm(mh, mm)));
        chk({tag, ".ctl"}, 16'(dut_ctl()), 16'(c));
    endtask
    task automatic step(input logic [3:0] b);
        {b_mode, b_next, b_inc, b_ok} = b;
        @(posedge clk);
        model_clk(b);
        #1;
        check_all("step");
    endtask
    task automatic press(input logic [3:0] b);
        step(b);
        step(4'b0000);
    endtask
    task automatic set_cur(input int h, input int m);
        {cur_H1, cur_H0, cur_M1, cur_M0} = hm(h, m);
    endtask
    initial begin
        logic [13:0] pre;
        logic [3:0] rb;
        // reset with mode held through release: no edge may fire
        {b_mode, b_next, b_inc, b_ok} = 4'b1000;
        set_cur(13, 47);
        #2 reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.time", 16'(dut_digits()), 16'h0);
        chk("rst.ctl", 16'(dut_ctl()), 16'h0);
        @(negedge clk) reset = 1'b1;
        repeat (3) step(4'b1000);
        chk("rst.held_mode", 16'(editing), 16'h0);
        // table: 13:47 -> edit H0 -> 14:47 -> time load
        tbl[0]  = '{4'b0000, hm(0, 0),   6'b000000};
        tbl[1]  = '{4'b1000, hm(13, 47), 6'b001000};
        tbl[2]  = '{4'b0000, hm(13, 47), 6'b001000};
        tbl[3]  = '{4'b0100, hm(13, 47), 6'b001001};
        tbl[4]  = '{4'b0000, hm(13, 47), 6'b001001};
        tbl[5]  = '{4'b0010, hm(14, 47), 6'b001001};
        tbl[6]  = '{4'b0000, hm(14, 47), 6'b001001};
        tbl[7]  = '{4'b0001, hm(14, 47), 6'b100001};
        tbl[8]  = '{4'b0000, hm(14, 47), 6'b100001};
        tbl[9]  = '{4'b0000, hm(14, 47), 6'b000001};
        tbl[10] = '{4'b0000, hm(14, 47), 6'b000001};
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].b);
            chk($sformatf("tbl%0d.time", i), 16'(dut_digits()), 16'(tbl[i].digits));
            chk($sformatf("tbl%0d.ctl", i), 16'(dut_ctl()), 16'(tbl[i].ctl));
        end
        // H1 clamp and digit wraps from 19:59
        set_cur(19, 59);
        press(4'b1000);
        chk("clamp.load", 16'(dut_digits()), 16'(hm(19, 59)));
        press(4'b0010);
        chk("clamp.h1", 16'(dut_digits()), 16'(hm(23, 59)));
        repeat (3) press(4'b0100);
        press(4'b0010);
        chk("clamp.m0", 16'(dut_digits()), 16'(hm(23, 50)));
        repeat (2) press(4'b0100);
        press(4'b0010);
        chk("clamp.h0", 16'(dut_digits()), 16'(hm(20, 50)));
        press(4'b1000);
        press(4'b1000);
        chk("clamp.abort", 16'(editing | bus.LD_time | bus.LD_alarm), 16'h0);
        // alarm edit to 06:30 and commit
        press(4'b1000);
        press(4'b1000);
        chk("alarm.enter", 16'({edit_alarm, dut_digits()}), 16'({1'b1, hm(0, 0)}));
        press(4'b0100);
        repeat (6) press(4'b0010);
        press(4'b0100);
        repeat (3) press(4'b0010);
        chk("alarm.edit", 16'(dut_digits()), 16'(hm(6, 30)));
        step(4'b0001);
        chk("alarm.ld1", 16'({bus.LD_time, bus.LD_alarm}), 16'b01);
        step(4'b0000);
        chk("alarm.ld2", 16'({bus.LD_time, bus.LD_alarm}), 16'b01);
        step(4'b0000);
        chk("alarm.ld_end", 16'({bus.LD_time, bus.LD_alarm}), 16'b00);
        press(4'b1000);
        press(4'b1000);
        chk("alarm.preload", 16'(dut_digits()), 16'(hm(6, 30)));
        press(4'b1000);
        // timeout with no buttons, then kept alive by periodic inc
        press(4'b1000);
        repeat (10) step(4'b0000);
        chk("timeout.fired", 16'({editing, bus.LD_time, bus.LD_alarm}), 16'h0);
        press(4'b1000);
        repeat (8) begin
            press(4'b0010);
            repeat (3) step(4'b0000);
        end
        chk("timeout.alive", 16'(editing), 16'h1);
        press(4'b1000);
        press(4'b1000);
        // ok and inc together commit the pre-increment value; reset in LOAD
        press(4'b1000);
        pre = dut_digits();
        step(4'b0011);
        chk("okinc.strobe", 16'(bus.LD_time), 16'h1);
        chk("okinc.value", 16'(dut_digits()), 16'(pre));
        step(4'b0000);
        reset = 1'b0;
        #1;
        chk("rst_load.ld", 16'({bus.LD_time, bus.LD_alarm, editing}), 16'h0);
        model_reset();
        @(negedge clk) reset = 1'b1;
        step(4'b0000);
        press(4'b1000);
        press(4'b1000);
        chk("rst_load.shadow", 16'({edit_alarm, dut_digits()}), 16'({1'b1, hm(0, 0)}));
        press(4'b1000);
        // randomized run against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) set_cur($urandom_range(0, 23), $urandom_range(0, 59));
            for (int k = 0; k < 4; k++) rb[k] = ($urandom_range(0, 3) == 0);
            step(rb);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
